// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// rr_arb_mux : registered N:1 channel mux with round-robin / fixed-priority
//              arbitration and valid/ready handshake on every channel.
// Revision   : 1.0
// ============================================================================
module rr_arb_mux #(
  parameter int S    = 2,
  parameter int T    = 8,
  parameter int MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2**S-1:0]     in_valid,
  input  logic [(2**S)*T-1:0] in_data,
  output logic [2**S-1:0]     in_ready,
  output logic                out_valid,
  output logic [T-1:0]        out_data,
  output logic [S-1:0]        out_sel,
  input  logic                out_ready
);

  localparam int N = 2**S;

  logic [S-1:0] ptr;
  logic [S-1:0] start;
  logic [S-1:0] idx;
  logic [S-1:0] gidx;
  logic [N-1:0] grant;
  logic         found;
  logic         load;

  assign load  = ~out_valid | out_ready;
  // Fixed priority is simply a round-robin search that always starts at 0.
  assign start = (MODE == 1) ? ptr : '0;

  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = start + S'(k);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        gidx       = idx;
      end
    end
  end

  assign in_ready = rst_n ? (grant & {N{load}}) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= in_data[gidx*T +: T];
        out_sel  <= gidx;
        if (MODE == 1) begin
          ptr <= gidx + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// tb_rr_arb_mux : bench for rr_arb_mux, round-robin and fixed-priority copies.
// Revision      : 1.0
// ============================================================================
module tb_rr_arb_mux;

  localparam int S = 2;
  localparam int T = 8;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fp_in_ready;
  logic        rr_out_valid, fp_out_valid;
  logic [7:0]  rr_out_data, fp_out_data;
  logic [1:0]  rr_out_sel, fp_out_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.S(S), .T(T), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  rr_arb_mux #(.S(S), .T(T), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: winner is the requesting channel at the smallest distance from the
  // start point (ptr for round-robin, 0 for fixed priority); -1 if none.
  function automatic int pick(input int mode, input int ptr, input logic [3:0] v);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = mode ? ((i - ptr + N) % N) : i;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // index 0 = fixed priority instance, index 1 = round-robin instance
  int         m_ptr [2];
  logic       m_ov  [2];
  logic [7:0] m_od  [2];
  int         m_os  [2];
  logic       seen = 1'b0;

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int b;
      b = pick(j, m_ptr[j], in_valid);
      if (!rst_n) begin
        m_ov[j]  <= 1'b0;
        m_od[j]  <= 8'h00;
        m_os[j]  <= 0;
        m_ptr[j] <= 0;
      end else if (!m_ov[j] || out_ready) begin
        if (b >= 0) begin
          m_ov[j]  <= 1'b1;
          m_od[j]  <= in_data[b*8 +: 8];
          m_os[j]  <= b;
          m_ptr[j] <= j ? ((b + 1) % N) : 0;
        end else begin
          m_ov[j] <= 1'b0;
        end
      end
    end
    if (!rst_n) seen <= 1'b1;
  end

  always @(negedge clk) begin
    if (seen) begin
      for (int j = 0; j < 2; j++) begin
        int         b;
        logic [3:0] er;
        b  = pick(j, m_ptr[j], in_valid);
        er = (rst_n && (!m_ov[j] || out_ready) && b >= 0) ? 4'(1 << b) : 4'b0;
        chk(j ? "rr_in_ready" : "fp_in_ready", j ? 32'(rr_in_ready) : 32'(fp_in_ready), 32'(er));
        chk(j ? "rr_out_valid" : "fp_out_valid", j ? 32'(rr_out_valid) : 32'(fp_out_valid), 32'(m_ov[j]));
        chk(j ? "rr_out_data" : "fp_out_data", j ? 32'(rr_out_data) : 32'(fp_out_data), 32'(m_od[j]));
        chk(j ? "rr_out_sel" : "fp_out_sel", j ? 32'(rr_out_sel) : 32'(fp_out_sel), 32'(m_os[j]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("reset_in_ready", 32'(rr_in_ready), 32'h0);
    chk("reset_out_valid", 32'(rr_out_valid), 32'h0);
    chk("reset_out_data", 32'(rr_out_data), 32'h00);
    chk("reset_out_sel", 32'(rr_out_sel), 32'h0);

    rst_n = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
    tick();

    // single channel
    in_valid = 4'b0100; in_data = 32'h00A5_0000;
    #1;
    chk("single_rr_ready", 32'(rr_in_ready), 32'h4);
    chk("single_fp_ready", 32'(fp_in_ready), 32'h4);
    tick();
    chk("single_valid", 32'(rr_out_valid), 32'h1);
    chk("single_data", 32'(rr_out_data), 32'hA5);
    chk("single_sel", 32'(rr_out_sel), 32'h2);

    // wrap: ptr is now 3
    in_valid = 4'b1001; in_data = 32'h4433_2211;
    #1;
    chk("wrap_rr_ready3", 32'(rr_in_ready), 32'h8);
    chk("wrap_fp_ready0", 32'(fp_in_ready), 32'h1);
    tick();
    chk("wrap_sel3", 32'(rr_out_sel), 32'h3);
    chk("wrap_data3", 32'(rr_out_data), 32'h44);
    chk("wrap_rr_ready0", 32'(rr_in_ready), 32'h1);
    tick();
    chk("wrap_sel0", 32'(rr_out_sel), 32'h0);
    chk("wrap_data0", 32'(rr_out_data), 32'h11);

    // fairness, ptr is now 1
    in_valid = 4'hF; in_data = 32'hD4C3_B2A1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_fair_sel", 32'(rr_out_sel), 32'((1 + i) % 4));
      chk("fp_prio_sel", 32'(fp_out_sel), 32'h0);
    end

    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rr_ready", 32'(rr_in_ready), 32'h0);
      chk("stall_fp_ready", 32'(fp_in_ready), 32'h0);
      chk("stall_rr_data", 32'(rr_out_data), 32'hA1);
      chk("stall_rr_sel", 32'(rr_out_sel), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("resume_rr_ready", 32'(rr_in_ready), 32'h2);
    tick();
    chk("resume_rr_sel", 32'(rr_out_sel), 32'h1);
    chk("resume_rr_data", 32'(rr_out_data), 32'hB2);

    // fixed priority with a sparse request set
    in_valid = 4'b1010;
    #1;
    chk("fp_sparse_ready", 32'(fp_in_ready), 32'h2);
    tick();
    chk("fp_sparse_sel", 32'(fp_out_sel), 32'h1);
    chk("rr_sparse_sel", 32'(rr_out_sel), 32'h3);
    chk("rr_sparse_data", 32'(rr_out_data), 32'hD4);

    // idle drain keeps data and sel
    in_valid = 4'h0;
    tick();
    chk("idle_valid", 32'(rr_out_valid), 32'h0);
    chk("idle_sel_hold", 32'(rr_out_sel), 32'h3);
    chk("idle_data_hold", 32'(rr_out_data), 32'hD4);

    // reset mid-stream
    in_valid = 4'b0100; out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(rr_out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_ready", 32'(rr_in_ready), 32'h0);
    tick();
    chk("post_rst_valid", 32'(rr_out_valid), 32'h0);
    chk("post_rst_fp_valid", 32'(fp_out_valid), 32'h0);
    rst_n = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rr_in_ready), 32'h1);
    tick();
    chk("post_rst_sel", 32'(rr_out_sel), 32'h0);
    chk("post_rst_data", 32'(rr_out_data), 32'hA1);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 16; i++) begin
      logic [3:0] pat [4];
      pat[0] = 4'b0110; pat[1] = 4'b1001; pat[2] = 4'b1111; pat[3] = 4'b0000;
      in_valid  = pat[i % 4];
      in_data   = 32'h1020_3040 + 32'(i);
      out_ready = (i % 3) != 0;
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
